axi4_rd_arbiter: RTL and testbench
==================================

Name: axi4_rd_arbiter

Overview:
Parametrised AXI4 read master that merges NUM_REQ independent read requesters (fetch, LSU, ...) onto one AXI4 AR/R channel pair. Round-robin arbitration on AR, one outstanding burst per requester, response routing by ARID/RID, and burst-length checking on R. Sits between the core front-end/LSU and the core's AXI read port, replacing the single-requester fetch read FSM.

Parameters:
NUM_REQ, 2, number of requester ports (>=1); requester i uses AXI ID i.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 64, AXI data width (power of 2, >=32).
ID_WIDTH, 1, AXI ID width; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  request valid, per requester.
req_ready  out  NUM_REQ  request accepted; one-hot or zero.
req_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses, requester i at slice i.
req_len  in  NUM_REQ*8  packed AXI burst length (beats-1).
req_size  in  NUM_REQ*3  packed AXI beat size.
resp_valid  out  NUM_REQ  beat valid for requester i.
resp_ready  in  NUM_REQ  requester accepts beat.
resp_data  out  DATA_WIDTH  shared beat data (qualify with resp_valid).
resp_resp  out  2  shared RRESP.
resp_last  out  1  shared RLAST.
axi_arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AR channel.
axi_arlock/arcache/arprot/arqos/arregion  out  1/4/3/4/4  constant 0.
axi_arready  in  1.
axi_rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1  R channel.
axi_rready  out  1.
busy  out  NUM_REQ  burst outstanding per requester.
err_unexpected  out  1  sticky: beat received for an ID with no outstanding burst.
err_len  out  1  sticky: RLAST early or missing.

Behaviour:
- Reset: arvalid=0, araddr/arid/arlen/arsize=0, arburst=2'b01, busy=0, req_ready=0, both err flags=0, rr pointer=0, FSM=IDLE, beat counters=0.
- AR FSM, states IDLE, ADDR.
- IDLE: eligible[i]=req_valid[i]&~busy[i]. If any eligible, grant the first eligible at or after rr pointer (wrapping) and assert req_ready[grant] combinationally that cycle. Latch addr/len/size, arid=grant, set busy[grant], rr pointer=grant+1 mod NUM_REQ; next state ADDR. req_ready=0 in every other state.
- ADDR: arvalid=1; AR fields registered and stable until handshake. On arready go to IDLE, arvalid=0 next cycle. Max AR rate is one per 2 cycles.
- arburst always INCR (2'b01).
- R routing: hit = rid<NUM_REQ & busy[rid]. If hit, resp_valid[rid]=axi_rvalid, axi_rready=resp_ready[rid], other resp_valid=0. If not hit, axi_rready=1, beat discarded, err_unexpected set on handshake.
- resp_data/resp_resp/resp_last are combinational pass-through of rdata/rresp/rlast; zero added latency.
- Per-requester 8-bit beat counter, cleared on AR grant, incremented on each hit handshake. On handshake with count==len, rlast must be 1, else err_len. On handshake with rlast=1, count must be ==len, else err_len. A handshake with rlast=1 clears busy[rid], regardless of error.
- Simultaneous events:
  - Busy is set only for a non-busy requester, so AR-grant set and R-last clear cannot hit the same index in one cycle.
  - Different indices update independently.
  - A requester may re-request in the cycle after its last beat.
- Interleaved R beats across IDs are supported.
- RRESP is passed through unchanged; SLVERR/DECERR is not an error-flag condition.
- Reset mid-burst: all state returns to reset values at the next edge and in-flight beats are forgotten. System reset is assumed to cover the slave.

Test Plan:
- Single fetch: req0 addr=0x1000 len=1 size=3, arready=1 -> req_ready[0] in the grant cycle; arvalid next cycle with araddr=0x1000 arlen=1 arid=0; 2 beats routed to resp_valid[0]; busy[0] clears after the rlast beat.
- Contention: req0 and req1 held valid continuously with immediate responses -> grants alternate 0,1,0,1; no requester is granted twice while the other is eligible.
- AR backpressure: arready low for 5 cycles -> arvalid held high, araddr/arid/arlen unchanged; no new req_ready until the handshake.
- Interleaved R: both outstanding (len=3 and len=1), beats arrive with RID 1,0,1,0,0,0 -> each beat appears only on its own resp_valid; both busy bits clear on their respective rlast; err flags stay 0.
- Errors:
  - Beat with RID=1 while busy[1]=0 -> axi_rready=1, no resp_valid asserted, err_unexpected=1 and sticky.
  - len=2 burst with rlast on beat 1 -> err_len=1, busy cleared.
- Backpressure and reset: resp_ready[0]=0 for 3 cycles -> axi_rready=0 and the beat is held. Assert rst mid-burst -> next cycle arvalid=0, busy=0, err flags=0.

Source files
------------

// File: rtl/axi4_rd_arbiter.sv
// AXI4 read master merging NUM_REQ requesters onto one AR/R pair.
// Round-robin AR grant, one outstanding burst per requester, RID-based R routing.
module axi4_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_len,
  input  logic [NUM_REQ*3-1:0]      req_size,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic [1:0]                resp_resp,
  output logic                      resp_last,
  output logic [ID_WIDTH-1:0]       axi_arid,
  output logic [ADDR_WIDTH-1:0]     axi_araddr,
  output logic [7:0]                axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  output logic                      axi_arlock,
  output logic [3:0]                axi_arcache,
  output logic [2:0]                axi_arprot,
  output logic [3:0]                axi_arqos,
  output logic [3:0]                axi_arregion,
  input  logic                      axi_arready,
  input  logic [ID_WIDTH-1:0]       axi_rid,
  input  logic [DATA_WIDTH-1:0]     axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [NUM_REQ-1:0]        busy,
  output logic                      err_unexpected,
  output logic                      err_len
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ADDR} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        grant;
  logic [IDX_W-1:0]        hi_idx;
  logic [IDX_W-1:0]        lo_idx;
  logic                    found_hi;
  logic                    any_elig;
  logic                    grant_fire;
  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      hit_vec;
  logic                    hit;
  logic                    r_hs;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
  logic [7:0]              len_arr  [NUM_REQ];
  logic [2:0]              size_arr [NUM_REQ];
  logic [7:0]              cnt      [NUM_REQ];
  logic [7:0]              len_q    [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      len_arr[i]  = req_len[i*8 +: 8];
      size_arr[i] = req_size[i*3 +: 3];
    end
  end

  assign eligible   = req_valid & ~busy;
  assign any_elig   = |eligible;
  assign grant_fire = (state == IDLE) && any_elig;

  // Downward scan leaves the lowest eligible index at/after rr_ptr in hi_idx,
  // and the lowest eligible index overall in lo_idx for the wrap case.
  always_comb begin
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    grant = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_fire && (grant == IDX_W'(i));
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_vec[i] = busy[i] && (axi_rid == ID_WIDTH'(i));
    end
  end

  // Beats for IDs with nothing outstanding are drained so the bus never stalls.
  assign hit        = |hit_vec;
  assign resp_valid = axi_rvalid ? hit_vec : '0;
  assign axi_rready = hit ? |(hit_vec & resp_ready) : 1'b1;
  assign r_hs       = axi_rvalid && axi_rready;

  assign resp_data  = axi_rdata;
  assign resp_resp  = axi_rresp;
  assign resp_last  = axi_rlast;

  assign axi_arburst  = 2'b01;
  assign axi_arlock   = 1'b0;
  assign axi_arcache  = 4'd0;
  assign axi_arprot   = 3'd0;
  assign axi_arqos    = 4'd0;
  assign axi_arregion = 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_arid    <= '0;
      axi_arlen   <= '0;
      axi_arsize  <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            axi_araddr  <= addr_arr[grant];
            axi_arlen   <= len_arr[grant];
            axi_arsize  <= size_arr[grant];
            axi_arid    <= ID_WIDTH'(grant);
            axi_arvalid <= 1'b1;
            rr_ptr      <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant and last-beat cannot target the same index: grant requires ~busy, a hit requires busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= '0;
      err_unexpected <= 1'b0;
      err_len        <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (r_hs && !hit) begin
        err_unexpected <= 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_fire && (grant == IDX_W'(i))) begin
          busy[i]  <= 1'b1;
          cnt[i]   <= '0;
          len_q[i] <= len_arr[i];
        end else if (r_hs && hit_vec[i]) begin
          cnt[i] <= cnt[i] + 8'd1;
          if ((cnt[i] == len_q[i]) != axi_rlast) begin
            err_len <= 1'b1;
          end
          if (axi_rlast) begin
            busy[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed self-checking bench for axi4_rd_arbiter (NUM_REQ=2, ID_WIDTH=1).
module tb_axi4_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic [5:0]  req_size;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [63:0] resp_data;
  logic [1:0]  resp_resp;
  logic        resp_last;
  logic [0:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arlock;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic [3:0]  axi_arqos;
  logic [3:0]  axi_arregion;
  logic        axi_arready;
  logic [0:0]  axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [1:0]  busy;
  logic        err_unexpected;
  logic        err_len;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi4_rd_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_resp(resp_resp), .resp_last(resp_last),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arlock(axi_arlock), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arqos(axi_arqos), .axi_arregion(axi_arregion), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .busy(busy), .err_unexpected(err_unexpected), .err_len(err_len)
  );

  // Inputs are driven 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; req_size = '0;
    resp_ready = 2'b11; axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0;
    axi_rresp = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0;
    tick();
    tick();
    #1;
    n_checks++;
    if (axi_arvalid !== 1'b0 || axi_araddr !== 32'h0 || axi_arlen !== 8'h0 || axi_arid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ar: arvalid=%b araddr=%h arlen=%h arid=%b required 0", axi_arvalid, axi_araddr, axi_arlen, axi_arid);
    end
    n_checks++;
    if (axi_arburst !== 2'b01) begin
      n_fail++; $display("FAIL reset_arburst: got %b required 01", axi_arburst);
    end
    n_checks++;
    if (busy !== 2'b00 || req_ready !== 2'b00 || err_unexpected !== 1'b0 || err_len !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b req_ready=%b errs=%b%b required 0", busy, req_ready, err_unexpected, err_len);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch;
    req_valid = 2'b01; req_addr[31:0] = 32'h1000; req_len[7:0] = 8'd1; req_size[2:0] = 3'd3;
    axi_arready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_grant: req_ready=%b required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h1000 || axi_arlen !== 8'd1 || axi_arid !== 1'b0 || axi_arsize !== 3'd3) begin
      n_fail++; $display("FAIL single_ar: arvalid=%b araddr=%h arlen=%0d arid=%b arsize=%0d required 1/1000/1/0/3",
                         axi_arvalid, axi_araddr, axi_arlen, axi_arid, axi_arsize);
    end
    n_checks++;
    if (busy !== 2'b01 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL single_busy: busy=%b req_ready=%b required 01/00", busy, req_ready);
    end
    tick();
    axi_rvalid = 1'b1; axi_rid = 1'b0; axi_rdata = 64'hA5A5_0000_0000_0001; axi_rlast = 1'b0; axi_rresp = 2'b00;
    #1;
    n_checks++;
    if (axi_arvalid !== 1'b0 || resp_valid !== 2'b01 || axi_rready !== 1'b1 || resp_data !== 64'hA5A5_0000_0000_0001) begin
      n_fail++; $display("FAIL single_beat0: arvalid=%b resp_valid=%b rready=%b data=%h", axi_arvalid, resp_valid, axi_rready, resp_data);
    end
    tick();
    axi_rdata = 64'hA5A5_0000_0000_0002; axi_rlast = 1'b1; axi_rresp = 2'b10;
    #1;
    n_checks++;
    if (resp_valid !== 2'b01 || resp_last !== 1'b1 || resp_resp !== 2'b10 || resp_data !== 64'hA5A5_0000_0000_0002) begin
      n_fail++; $display("FAIL single_beat1: resp_valid=%b last=%b resp=%b data=%h", resp_valid, resp_last, resp_resp, resp_data);
    end
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
    #1;
    n_checks++;
    if (busy !== 2'b00 || err_len !== 1'b0 || err_unexpected !== 1'b0) begin
      n_fail++; $display("FAIL single_done: busy=%b err_len=%b err_unexp=%b required 00/0/0", busy, err_len, err_unexpected);
    end
  endtask

  task automatic test_contention;
    int    exp_grant [4] = '{0, 1, 0, 1};
    int    ng = 0;
    logic  pend_v = 1'b0;
    logic  pend_id = 1'b0;
    do_reset();
    req_valid = 2'b11; req_len = '0; axi_arready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (ng == 4) req_valid = 2'b00;
      axi_rvalid = pend_v; axi_rid = pend_id; axi_rlast = 1'b1;
      pend_v = 1'b0;
      #1;
      if (req_ready != 2'b00) begin
        n_checks++;
        if (ng >= 4 || req_ready !== (2'b01 << exp_grant[ng])) begin
          n_fail++; $display("FAIL contention_grant%0d: req_ready=%b", ng, req_ready);
        end
        ng++;
      end
      if (axi_arvalid) begin
        pend_v = 1'b1; pend_id = axi_arid;
      end
      tick();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    n_checks++;
    if (ng !== 4) begin
      n_fail++; $display("FAIL contention_count: grants=%0d required 4", ng);
    end
    n_checks++;
    if (busy !== 2'b00 || err_len !== 1'b0 || err_unexpected !== 1'b0) begin
      n_fail++; $display("FAIL contention_done: busy=%b errs=%b%b required 00/00", busy, err_unexpected, err_len);
    end
  endtask

  task automatic test_ar_backpressure;
    req_valid = 2'b11; req_addr = {32'h3000, 32'h2000}; req_len = '0; axi_arready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL bp_grant0: req_ready=%b required 01", req_ready);
    end
    tick();
    req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h2000 || axi_arid !== 1'b0 || axi_arlen !== 8'd0 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_hold%0d: arvalid=%b araddr=%h arid=%b arlen=%0d req_ready=%b",
                           c, axi_arvalid, axi_araddr, axi_arid, axi_arlen, req_ready);
      end
      tick();
    end
    axi_arready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (axi_arvalid !== 1'b0 || req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: arvalid=%b req_ready=%b required 0/10", axi_arvalid, req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h3000 || axi_arid !== 1'b1 || axi_arburst !== 2'b01) begin
      n_fail++; $display("FAIL bp_ar1: arvalid=%b araddr=%h arid=%b arburst=%b", axi_arvalid, axi_araddr, axi_arid, axi_arburst);
    end
    tick();
    axi_rvalid = 1'b1; axi_rid = 1'b0; axi_rlast = 1'b1;
    tick();
    axi_rid = 1'b1;
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    n_checks++;
    if (busy !== 2'b00 || err_len !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: busy=%b err_len=%b required 00/0", busy, err_len);
    end
  endtask

  task automatic test_interleaved;
    logic [1:0] rids  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       lasts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] busy_after [6] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
    req_len = {8'd1, 8'd3}; axi_arready = 1'b1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL inter_grant1: req_ready=%b required 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++;
    if (busy !== 2'b11) begin
      n_fail++; $display("FAIL inter_busy: busy=%b required 11", busy);
    end
    for (int b = 0; b < 6; b++) begin
      axi_rvalid = 1'b1; axi_rid = rids[b][0]; axi_rlast = lasts[b]; axi_rdata = 64'(b + 16);
      #1;
      n_checks++;
      if (resp_valid !== (2'b01 << rids[b]) || resp_data !== 64'(b + 16) || axi_rready !== 1'b1) begin
        n_fail++; $display("FAIL inter_beat%0d: resp_valid=%b data=%h rready=%b", b, resp_valid, resp_data, axi_rready);
      end
      tick();
      n_checks++;
      if (busy !== busy_after[b]) begin
        n_fail++; $display("FAIL inter_busy%0d: busy=%b required %b", b, busy, busy_after[b]);
      end
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    n_checks++;
    if (err_len !== 1'b0 || err_unexpected !== 1'b0) begin
      n_fail++; $display("FAIL inter_errs: err_unexp=%b err_len=%b required 0/0", err_unexpected, err_len);
    end
  endtask

  task automatic test_errors;
    axi_rvalid = 1'b1; axi_rid = 1'b1; axi_rlast = 1'b1;
    #1;
    n_checks++;
    if (axi_rready !== 1'b1 || resp_valid !== 2'b00) begin
      n_fail++; $display("FAIL unexp_drain: rready=%b resp_valid=%b required 1/00", axi_rready, resp_valid);
    end
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    tick();
    tick();
    n_checks++;
    if (err_unexpected !== 1'b1 || err_len !== 1'b0) begin
      n_fail++; $display("FAIL unexp_sticky: err_unexp=%b err_len=%b required 1/0", err_unexpected, err_len);
    end
    req_valid = 2'b01; req_len = {8'd0, 8'd2}; axi_arready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    axi_rvalid = 1'b1; axi_rid = 1'b0; axi_rlast = 1'b0;
    tick();
    n_checks++;
    if (err_len !== 1'b0) begin
      n_fail++; $display("FAIL len_beat0: err_len=%b required 0", err_len);
    end
    axi_rlast = 1'b1;
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    n_checks++;
    if (err_len !== 1'b1 || busy !== 2'b00) begin
      n_fail++; $display("FAIL len_early: err_len=%b busy=%b required 1/00", err_len, busy);
    end
  endtask

  task automatic test_backpressure_reset;
    do_reset();
    req_valid = 2'b01; req_addr[31:0] = 32'h4000; req_len = {8'd0, 8'd1}; axi_arready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    axi_rvalid = 1'b1; axi_rid = 1'b0; axi_rlast = 1'b0; axi_rdata = 64'hD0D0; resp_ready = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (axi_rready !== 1'b0 || resp_valid !== 2'b01 || resp_data !== 64'hD0D0 || busy !== 2'b01) begin
        n_fail++; $display("FAIL rbp_hold%0d: rready=%b resp_valid=%b data=%h busy=%b", c, axi_rready, resp_valid, resp_data, busy);
      end
      tick();
    end
    resp_ready = 2'b11;
    #1;
    n_checks++;
    if (axi_rready !== 1'b1) begin
      n_fail++; $display("FAIL rbp_release: rready=%b required 1", axi_rready);
    end
    tick();
    axi_rid = 1'b1; axi_rlast = 1'b1;
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    req_valid = 2'b10; axi_arready = 1'b0;
    tick();
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (axi_arvalid !== 1'b1 || busy !== 2'b11 || err_unexpected !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: arvalid=%b busy=%b err_unexp=%b required 1/11/1", axi_arvalid, busy, err_unexpected);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (axi_arvalid !== 1'b0 || busy !== 2'b00 || err_unexpected !== 1'b0 || err_len !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: arvalid=%b busy=%b errs=%b%b required 0/00/00", axi_arvalid, busy, err_unexpected, err_len);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    req_addr = '0; req_len = '0; req_size = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_ar_backpressure();
    test_interleaved();
    test_errors();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
